cavlc_runlevel_pbuf: RTL and testbench
======================================

// Module: cavlc_runlevel_pbuf
// PURPOSE
//  Parametrised ping-pong register buffer for CAVLC run/level entries.
//  The scan stage writes LANES entries/cycle into one bank while the
//  bitstream packer reads LANES entries/cycle from the other bank.
//  Banks swap by a done/valid handshake; a drained bank is cleared on release.
// PARAMETERS
//  DATAWIDTH  8   width of one entry (run or level code)
//  DEPTH      16  entries per bank; must be a power of 2
//  ADDRWIDTH  4   log2(DEPTH)
//  LANES      2   entries written/read per cycle; 1 <= LANES <= DEPTH
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  reset, asynchronous, active-low
//  wr_addr        in   ADDRWIDTH          base write address, lane k -> wr_addr+k
//  wr_data        in   LANES*DATAWIDTH    lane k at [k*DATAWIDTH +: DATAWIDTH]
//  wr_en          in   LANES              per-lane write enable
//  wr_done        in   1                  pulse: write bank complete, hand over
//  wr_ready       out  1                  write bank is free (comb)
//  rd_addr        in   ADDRWIDTH          base read address, lane k -> rd_addr+k
//  rd_en          in   1                  read request
//  rd_done        in   1                  pulse: read bank consumed, release it
//  rd_bank_valid  out  1                  a filled bank is readable (comb)
//  rd_count       out  ADDRWIDTH+1        entries held in read bank (high-water mark)
//  rd_data        out  LANES*DATAWIDTH    registered read data, same lane packing
//  rd_valid       out  1                  rd_data updated this cycle
// BEHAVIOUR
//  State: mem[2][DEPTH], full[1:0], wr_sel, rd_sel, hwm[1:0] (ADDRWIDTH+1 b).
//  Reset (async): all mem=0, full=0, wr_sel=rd_sel=0, hwm=0, rd_data=0, rd_valid=0.
//  wr_ready = !full[wr_sel];  rd_bank_valid = full[rd_sel];  rd_count = hwm[rd_sel].
//  Write: if wr_ready and wr_en[k]: mem[wr_sel][(wr_addr+k) mod DEPTH] <= lane k.
//   Address wraps modulo DEPTH (no carry out). wr_en=0 lanes leave entries intact.
//   hwm[wr_sel] <= max(hwm, wrapped addr+1) over enabled lanes; a wrapped lane
//   (addr+k >= DEPTH) sets hwm=DEPTH. Max value DEPTH, never exceeds it.
//   Writes while !wr_ready are dropped silently; no state changes.
//  wr_done (honoured only when wr_ready): full[wr_sel]<=1, wr_sel toggles.
//   A write in the same cycle as wr_done lands in the closing bank and counts in hwm.
//   wr_done while !wr_ready is ignored.
//  Read: latency 1. rd_en & rd_bank_valid -> next cycle
//   rd_data lane k = mem[rd_sel][(rd_addr+k) mod DEPTH], rd_valid=1.
//   rd_en while !rd_bank_valid or rd_en=0 -> rd_valid=0, rd_data holds value.
//  rd_done (honoured only when rd_bank_valid): full[rd_sel]<=0, hwm[rd_sel]<=0,
//   all mem[rd_sel] entries <=0, rd_sel toggles. rd_en in the same cycle
//   returns pre-clear data. rd_done while !rd_bank_valid is ignored.
//  wr_done and rd_done in one cycle: both act (always on different banks, since
//   wr needs !full and rd needs full); bank states update independently.
//  Both banks full: wr_ready=0 until rd_done; it rises in the next cycle.
//  Reset mid-operation: all state and outputs return to reset values at once;
//   no partial bank survives.
// TESTING
//  1 Reset release -> wr_ready=1, rd_bank_valid=0, rd_count=0, rd_data=0, rd_valid=0.
//  2 Fill bank0 (DEPTH=16, LANES=2): addr0 en=11 data{22,11}, then addr2 en=01
//    data{xx,33} with wr_done -> rd_bank_valid=1, rd_count=3. rd_en addr0 -> next
//    cycle rd_data={22,11}, rd_valid=1.
//  3 Wrap: addr15 en=11 data{BB,AA} + wr_done -> rd_count=16; rd_en addr15 ->
//    rd_data={BB,AA}; rd_en addr0 -> rd_data lane0=BB.
//  4 Lane gating: addr4 en=10 data{55,44} -> mem[5]=55, mem[4] stays 0, rd_count=6.
//  5 Ping-pong: fill and wr_done both banks -> wr_ready=0, extra writes dropped.
//    rd_done -> next cycle wr_ready=1, rd_bank_valid=1 (bank1). Reading bank0
//    after its refill -> all entries not rewritten read 0.
//  6 Drop rst_n with both banks full and rd_en high -> outputs 0 the same cycle;
//    after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/cavlc_runlevel_pbuf.sv
// Ping-pong register buffer for CAVLC run/level entries: the scan stage fills one bank
// while the packer drains the other, with banks swapped by done/valid handshakes.
module cavlc_runlevel_pbuf #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int ADDRWIDTH = 4,
  parameter int LANES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDRWIDTH-1:0]         wr_addr_i,
  input  logic [LANES*DATAWIDTH-1:0]   wr_data_i,
  input  logic [LANES-1:0]             wr_en_i,
  input  logic                         wr_done_i,
  output logic                         wr_ready_o,
  input  logic [ADDRWIDTH-1:0]         rd_addr_i,
  input  logic                         rd_en_i,
  input  logic                         rd_done_i,
  output logic                         rd_bank_valid_o,
  output logic [ADDRWIDTH:0]           rd_count_o,
  output logic [LANES*DATAWIDTH-1:0]   rd_data_o,
  output logic                         rd_valid_o
);

  localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] ONE_W   = (ADDRWIDTH+1)'(1);

  logic [DATAWIDTH-1:0]         mem_q [2][DEPTH];
  logic [1:0]                   full_q, full_d;
  logic                         wr_sel_q, wr_sel_d;
  logic                         rd_sel_q, rd_sel_d;
  logic [1:0][ADDRWIDTH:0]      hwm_q, hwm_d;
  logic [LANES*DATAWIDTH-1:0]   rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;

  logic [ADDRWIDTH-1:0]         wr_lane_addr [LANES];
  logic [ADDRWIDTH-1:0]         rd_lane_addr [LANES];
  logic [ADDRWIDTH:0]           lane_hwm     [LANES];
  logic                         wr_done_ok, rd_done_ok, rd_ok;

  // A lane whose unwrapped address reaches DEPTH pins the high-water mark at DEPTH.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ADDRWIDTH:0] wr_sum;
    assign wr_sum            = {1'b0, wr_addr_i} + (ADDRWIDTH+1)'(gi);
    assign wr_lane_addr[gi]  = wr_sum[ADDRWIDTH-1:0];
    assign lane_hwm[gi]      = (wr_sum >= DEPTH_W) ? DEPTH_W : wr_sum + ONE_W;
    assign rd_lane_addr[gi]  = rd_addr_i + ADDRWIDTH'(gi);
  end

  assign wr_ready_o      = !full_q[wr_sel_q];
  assign rd_bank_valid_o = full_q[rd_sel_q];
  assign rd_count_o      = hwm_q[rd_sel_q];
  assign rd_data_o       = rd_data_q;
  assign rd_valid_o      = rd_valid_q;

  assign wr_done_ok = wr_done_i && wr_ready_o;
  assign rd_done_ok = rd_done_i && rd_bank_valid_o;
  assign rd_ok      = rd_en_i && rd_bank_valid_o;

  always_comb begin
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    hwm_d      = hwm_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;

    if (wr_ready_o) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_en_i[k] && (lane_hwm[k] > hwm_d[wr_sel_q])) hwm_d[wr_sel_q] = lane_hwm[k];
      end
    end
    if (wr_done_ok) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    // Write and read banks always differ when both handshakes fire together.
    if (rd_done_ok) begin
      full_d[rd_sel_q] = 1'b0;
      hwm_d[rd_sel_q]  = '0;
      rd_sel_d         = !rd_sel_q;
    end
    if (rd_ok) begin
      for (int k = 0; k < LANES; k++) begin
        rd_data_d[k*DATAWIDTH +: DATAWIDTH] = mem_q[rd_sel_q][rd_lane_addr[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      hwm_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      hwm_q      <= hwm_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) mem_q[b][i] <= '0;
      end
    end else begin
      if (rd_done_ok) begin
        for (int i = 0; i < DEPTH; i++) mem_q[rd_sel_q][i] <= '0;
      end
      if (wr_ready_o) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_en_i[k]) mem_q[wr_sel_q][wr_lane_addr[k]] <= wr_data_i[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_cavlc_runlevel_pbuf.sv
// Directed bench for cavlc_runlevel_pbuf (DEPTH=16, LANES=2) with hand-computed expectations.
module tb_cavlc_runlevel_pbuf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_en;
  logic        wr_done, wr_ready, rd_en, rd_done, rd_bank_valid, rd_valid;
  logic [4:0]  rd_count;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  cavlc_runlevel_pbuf #(.DATAWIDTH(8), .DEPTH(16), .ADDRWIDTH(4), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_en_i(wr_en), .wr_done_i(wr_done),
    .wr_ready_o(wr_ready),
    .rd_addr_i(rd_addr), .rd_en_i(rd_en), .rd_done_i(rd_done),
    .rd_bank_valid_o(rd_bank_valid), .rd_count_o(rd_count),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle();
    #12 rst_n = 1'b1;

    // Reset state
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);

    // rd_done with nothing readable must not move the read bank
    rd_done = 1'b1; step(); idle();

    // Fill bank0
    wr_addr = 4'd0; wr_en = 2'b11; wr_data = 16'h2211; step();
    wr_addr = 4'd2; wr_en = 2'b01; wr_data = 16'hEE33; wr_done = 1'b1; step(); idle();
    chk("b0_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
    chk("b0_rd_count", 32'(rd_count), 32'd3);
    chk("b0_wr_ready", 32'(wr_ready), 32'd1);
    rd_en = 1'b1; rd_addr = 4'd0; step();
    chk("b0_rd_addr0", 32'(rd_data), 32'h2211);
    chk("b0_rd_valid", 32'(rd_valid), 32'd1);
    rd_addr = 4'd2; step(); idle();
    chk("b0_rd_addr2", 32'(rd_data), 32'h0033);
    step();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_rd_hold", 32'(rd_data), 32'h0033);

    // Fill bank1 with a wrapping write; both banks then full
    wr_addr = 4'd15; wr_en = 2'b11; wr_data = 16'hBBAA; wr_done = 1'b1; step(); idle();
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_rd_count", 32'(rd_count), 32'd3);
    wr_addr = 4'd5; wr_en = 2'b11; wr_data = 16'hFFFF; wr_done = 1'b1; step(); idle();
    chk("drop_wr_ready", 32'(wr_ready), 32'd0);

    // Release bank0 with a same-cycle read returning pre-clear data
    rd_done = 1'b1; rd_en = 1'b1; rd_addr = 4'd0; step(); idle();
    chk("rel_pre_clear", 32'(rd_data), 32'h2211);
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);
    chk("rel_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
    chk("wrap_rd_count", 32'(rd_count), 32'd16);
    rd_en = 1'b1; rd_addr = 4'd15; step();
    chk("wrap_rd_addr15", 32'(rd_data), 32'hBBAA);
    rd_addr = 4'd0; step();
    chk("wrap_rd_addr0", 32'(rd_data), 32'h00BB);
    rd_addr = 4'd5; step(); idle();
    chk("dropped_write", 32'(rd_data), 32'h0000);

    // Lane-gated refill of bank0 while bank1 is released in the same cycle
    wr_addr = 4'd4; wr_en = 2'b10; wr_data = 16'h5544; wr_done = 1'b1; rd_done = 1'b1; step(); idle();
    chk("swap_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
    chk("swap_wr_ready", 32'(wr_ready), 32'd1);
    chk("gate_rd_count", 32'(rd_count), 32'd6);
    rd_en = 1'b1; rd_addr = 4'd4; step();
    chk("gate_rd_addr4", 32'(rd_data), 32'h5500);
    rd_addr = 4'd0; step();
    chk("cleared_addr0", 32'(rd_data), 32'h0000);
    rd_addr = 4'd2; step(); idle();
    chk("cleared_addr2", 32'(rd_data), 32'h0000);

    // Reset with both banks full and a read in flight
    wr_addr = 4'd0; wr_en = 2'b01; wr_data = 16'h0077; wr_done = 1'b1; step(); idle();
    chk("pre_rst_wr_ready", 32'(wr_ready), 32'd0);
    rd_en = 1'b1; rd_addr = 4'd4; step();
    chk("pre_rst_rd_data", 32'(rd_data), 32'h5500);
    chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    step();
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    chk("post_rst_rd_count", 32'(rd_count), 32'd0);
    step();
    chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("post_rst_rd_data", 32'(rd_data), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
